mem2axi_bridge: RTL and testbench

- Converts the core's simple memory request interface (cs/we/addr/byte/di/do/busy/err) into single-beat AXI4 master transactions.
- Sits directly upstream of one slave port (s0..s3) of the AXI 4-to-4 arbiter in the CPU memory subsystem; one instance each for the instruction and data ports.
- Exactly one outstanding transaction; no bursts, no reordering.

---
 rtl/mem2axi_bridge.sv | 145 ++++++++++++++
 tb/tb_mem2axi_bridge.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem2axi_bridge.sv
// mem2axi_bridge: turns simple cs/we memory requests into single-beat AXI4 transactions, one at a time
module mem2axi_bridge #(
    parameter int          ID_W   = 10,
    parameter int unsigned AXI_ID = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_cs,
    input  logic            s_we,
    input  logic [31:0]     s_addr,
    input  logic [3:0]      s_byte,
    input  logic [31:0]     s_di,
    output logic [31:0]     s_do,
    output logic            s_busy,
    output logic            s_err,
    output logic [ID_W-1:0] m_awid,
    output logic [31:0]     m_awaddr,
    output logic [7:0]      m_awlen,
    output logic [2:0]      m_awsize,
    output logic [1:0]      m_awburst,
    output logic            m_awvalid,
    input  logic            m_awready,
    output logic [31:0]     m_wdata,
    output logic [3:0]      m_wstrb,
    output logic            m_wlast,
    output logic            m_wvalid,
    input  logic            m_wready,
    input  logic [ID_W-1:0] m_bid,
    input  logic [1:0]      m_bresp,
    input  logic            m_bvalid,
    output logic            m_bready,
    output logic [ID_W-1:0] m_arid,
    output logic [31:0]     m_araddr,
    output logic [7:0]      m_arlen,
    output logic [2:0]      m_arsize,
    output logic [1:0]      m_arburst,
    output logic            m_arvalid,
    input  logic            m_arready,
    input  logic [ID_W-1:0] m_rid,
    input  logic [31:0]     m_rdata,
    input  logic [1:0]      m_rresp,
    input  logic            m_rlast,
    input  logic            m_rvalid,
    output logic            m_rready
);

    typedef enum logic [2:0] {IDLE, WR, BW, RD, RW, RESP} state_t;

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d, di_q, di_d, do_q, do_d;
    logic [3:0]  be_q, be_d;
    logic        err_q, err_d;
    logic        awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic        bready_q, bready_d, rready_q, rready_d;
    logic        unused;

    assign unused = ^{m_bid, m_rid, m_rlast, m_bresp[0], m_rresp[0]};

    // next state, request latch, response capture; channel controls derive from the next state
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        be_d    = be_q;
        di_d    = di_q;
        do_d    = do_q;
        err_d   = err_q;
        case (state_q)
            IDLE: if (s_cs) begin
                addr_d  = s_addr;
                be_d    = s_byte;
                di_d    = s_di;
                state_d = s_we ? WR : RD;
            end
            WR: if ((!awvalid_q || m_awready) && (!wvalid_q || m_wready)) state_d = BW;
            BW: if (m_bvalid) begin
                err_d   = m_bresp[1];
                state_d = RESP;
            end
            RD: if (m_arready) state_d = RW;
            RW: if (m_rvalid) begin
                do_d    = m_rdata;
                err_d   = m_rresp[1];
                state_d = RESP;
            end
            default: state_d = IDLE;
        endcase
        awvalid_d = (state_q == IDLE && state_d == WR) || (awvalid_q && !m_awready);
        wvalid_d  = (state_q == IDLE && state_d == WR) || (wvalid_q && !m_wready);
        arvalid_d = state_d == RD;
        bready_d  = state_d == BW;
        rready_d  = state_d == RW;
    end

    // state and registered outputs; reset abandons any transaction in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            be_q      <= '0;
            di_q      <= '0;
            do_q      <= '0;
            err_q     <= 1'b0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            bready_q  <= 1'b0;
            rready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            di_q      <= di_d;
            do_q      <= do_d;
            err_q     <= err_d;
            awvalid_q <= awvalid_d;
            wvalid_q  <= wvalid_d;
            arvalid_q <= arvalid_d;
            bready_q  <= bready_d;
            rready_q  <= rready_d;
        end
    end

    assign s_busy    = state_q == IDLE ? s_cs : state_q != RESP;
    assign s_do      = do_q;
    assign s_err     = err_q;
    assign m_awid    = ID_W'(AXI_ID);
    assign m_awaddr  = addr_q;
    assign m_awlen   = 8'd0;
    assign m_awsize  = 3'b010;
    assign m_awburst = 2'b01;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = di_q;
    assign m_wstrb   = be_q;
    assign m_wlast   = 1'b1;
    assign m_wvalid  = wvalid_q;
    assign m_bready  = bready_q;
    assign m_arid    = ID_W'(AXI_ID);
    assign m_araddr  = addr_q;
    assign m_arlen   = 8'd0;
    assign m_arsize  = 3'b010;
    assign m_arburst = 2'b01;
    assign m_arvalid = arvalid_q;
    assign m_rready  = rready_q;

endmodule

// File: tb/tb_mem2axi_bridge.sv
// tb_mem2axi_bridge: table-driven and randomized transactions against a cycle-timing reference model
module tb_mem2axi_bridge;

    localparam int          ID_W = 10;
    localparam int unsigned AID  = 37;

    logic            clk = 1'b0;
    logic            rst;
    logic            s_cs, s_we, s_busy, s_err;
    logic [31:0]     s_addr, s_di, s_do;
    logic [3:0]      s_byte;
    logic [ID_W-1:0] m_awid, m_arid, m_bid, m_rid;
    logic [31:0]     m_awaddr, m_araddr, m_wdata, m_rdata;
    logic [7:0]      m_awlen, m_arlen;
    logic [2:0]      m_awsize, m_arsize;
    logic [1:0]      m_awburst, m_arburst, m_bresp, m_rresp;
    logic [3:0]      m_wstrb;
    logic            m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready;
    logic            m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;

    mem2axi_bridge #(.ID_W(ID_W), .AXI_ID(AID)) dut (
        .clk(clk), .rst(rst),
        .s_cs(s_cs), .s_we(s_we), .s_addr(s_addr), .s_byte(s_byte), .s_di(s_di),
        .s_do(s_do), .s_busy(s_busy), .s_err(s_err),
        .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
        .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
        .m_wready(m_wready),
        .m_bid(m_bid), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_arid(m_arid), .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
        .m_arburst(m_arburst), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rid(m_rid), .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
        .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] di;
        int          aw_d, w_d, b_d, ar_d, r_d;
        logic [1:0]  resp;
        logic [31:0] rdata;
        logic        b2b;
        logic [31:0] exp_do;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        cs, we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] di;
    } req_t;

    int          nvec = 0;
    int          nerr = 0;
    logic [31:0] mdl_do;
    vec_t        vq[$];
    vec_t        tbl[6];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic slave_quiet();
        m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 0; m_rid = 0;
    endtask

    task automatic idle_chk();
        @(negedge clk);
        s_cs = 0;
        slave_quiet();
        #1;
        chk("idle busy", s_busy, 0);
        chk("idle ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
    endtask

    // slave timing: each ready/valid fires d cycles after the master side becomes eligible
    task automatic run_txn(input vec_t v, input req_t nx);
        int m, e;
        m = v.aw_d > v.w_d ? v.aw_d : v.w_d;
        e = v.we ? 3 + m + v.b_d : 3 + v.ar_d + v.r_d;
        for (int c = 0; c <= e; c++) begin
            @(negedge clk);
            if (c == 0) begin
                s_cs = 1; s_we = v.we; s_addr = v.addr; s_byte = v.be; s_di = v.di;
            end
            if (c == e) begin
                s_cs = nx.cs; s_we = nx.we; s_addr = nx.addr; s_byte = nx.be; s_di = nx.di;
            end
            m_awready = v.we && c == 1 + v.aw_d;
            m_wready  = v.we && c == 1 + v.w_d;
            m_bvalid  = v.we && c == 2 + m + v.b_d;
            m_bresp   = m_bvalid ? v.resp : 2'($urandom);
            m_bid     = ID_W'($urandom);
            m_arready = !v.we && c == 1 + v.ar_d;
            m_rvalid  = !v.we && c == 2 + v.ar_d + v.r_d;
            m_rdata   = m_rvalid ? v.rdata : $urandom;
            m_rresp   = m_rvalid ? v.resp : 2'($urandom);
            m_rlast   = 1'($urandom);
            m_rid     = ID_W'($urandom);
            #1;
            chk("s_busy", s_busy, c < e);
            chk("awvalid", m_awvalid, v.we && c >= 1 && c <= 1 + v.aw_d);
            chk("wvalid", m_wvalid, v.we && c >= 1 && c <= 1 + v.w_d);
            chk("bready", m_bready, v.we && c >= 2 + m && c <= 2 + m + v.b_d);
            chk("arvalid", m_arvalid, !v.we && c >= 1 && c <= 1 + v.ar_d);
            chk("rready", m_rready, !v.we && c >= 2 + v.ar_d && c <= 2 + v.ar_d + v.r_d);
            if (m_awvalid && m_awready)
                chk("aw fields", {m_awid, m_awaddr, m_awlen, m_awsize, m_awburst},
                    {ID_W'(AID), v.addr, 8'd0, 3'b010, 2'b01});
            if (m_wvalid && m_wready)
                chk("w fields", {m_wdata, m_wstrb, m_wlast}, {v.di, v.be, 1'b1});
            if (m_arvalid && m_arready)
                chk("ar fields", {m_arid, m_araddr, m_arlen, m_arsize, m_arburst},
                    {ID_W'(AID), v.addr, 8'd0, 3'b010, 2'b01});
            if (c == e) begin
                chk("s_do", s_do, v.exp_do);
                chk("s_err", s_err, v.exp_err);
            end
        end
    endtask

    initial begin
        req_t nx;
        vec_t v;
        rst = 1; s_cs = 0; s_we = 0; s_addr = 0; s_byte = 0; s_di = 0;
        slave_quiet();
        repeat (2) @(negedge clk);
        rst = 0;
        #1;
        chk("reset busy", s_busy, 0);
        chk("reset ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk("reset s_do", s_do, 0);
        chk("reset s_err", s_err, 0);
        s_cs = 1;
        #1;
        chk("idle busy follows cs", s_busy, 1);
        s_cs = 0;

        //          we addr            be       di            aw w b  ar r resp   rdata          b2b exp_do         err
        tbl[0] = '{0, 32'h8000_0010, 4'hF,    32'h0,        0, 0, 0, 0, 0, 2'b00, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0};
        tbl[1] = '{1, 32'h1000_0004, 4'b0011, 32'h1234_5678, 3, 0, 0, 0, 0, 2'b00, 32'h0,        0, 32'hDEAD_BEEF, 0};
        tbl[2] = '{1, 32'h2000_0008, 4'hF,    32'hCAFE_F00D, 0, 0, 1, 0, 0, 2'b10, 32'h0,        0, 32'hDEAD_BEEF, 1};
        tbl[3] = '{0, 32'h3000_0000, 4'hF,    32'h0,        0, 0, 0, 1, 0, 2'b01, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 0};
        tbl[4] = '{1, 32'h3000_0004, 4'b1100, 32'h5555_AAAA, 0, 2, 0, 0, 0, 2'b00, 32'h0,        1, 32'h0BAD_F00D, 0};
        tbl[5] = '{0, 32'h4000_0020, 4'hF,    32'h0,        0, 0, 0, 0, 5, 2'b11, 32'hA5A5_0F0F, 0, 32'hA5A5_0F0F, 1};
        mdl_do = 0;
        foreach (tbl[i]) begin
            vq.push_back(tbl[i]);
            if (!tbl[i].we) mdl_do = tbl[i].rdata;
        end

        // reference: reads return rdata, writes leave the last read data; err is resp[1]
        for (int i = 0; i < 40; i++) begin
            v.we = 1'($urandom); v.addr = $urandom; v.be = 4'($urandom); v.di = $urandom;
            v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
            v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 5);
            v.resp = 2'($urandom); v.rdata = $urandom; v.b2b = 1'($urandom);
            v.exp_do = v.we ? mdl_do : v.rdata;
            v.exp_err = v.resp[1];
            if (!v.we) mdl_do = v.rdata;
            vq.push_back(v);
        end

        foreach (vq[i]) begin
            if (vq[i].b2b && i + 1 < vq.size())
                nx = '{1'b1, vq[i+1].we, vq[i+1].addr, vq[i+1].be, vq[i+1].di};
            else
                nx = '{1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom};
            run_txn(vq[i], nx);
            if (!(vq[i].b2b && i + 1 < vq.size()))
                repeat ($urandom_range(1, 2)) idle_chk();
        end

        // reset while waiting for read data
        @(negedge clk);
        s_cs = 1; s_we = 0; s_addr = 32'h7000_0040; s_byte = 4'hF; s_di = 0;
        slave_quiet();
        #1;
        chk("rst seq busy", s_busy, 1);
        @(negedge clk);
        m_arready = 1;
        #1;
        chk("rst seq arvalid", m_arvalid, 1);
        @(negedge clk);
        m_arready = 0;
        #1;
        chk("rst seq rready", m_rready, 1);
        rst = 1;
        @(negedge clk);
        rst = 0; s_cs = 0;
        #1;
        chk("mid-rst busy", s_busy, 0);
        chk("mid-rst ctl", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        chk("mid-rst s_do", s_do, 0);
        chk("mid-rst s_err", s_err, 0);
        s_cs = 1;
        #1;
        chk("mid-rst busy follows cs", s_busy, 1);
        s_cs = 0;
        idle_chk();
        mdl_do = 0;
        v = '{1, 32'h7000_0044, 4'b0101, 32'h0F0F_F0F0, 1, 1, 0, 0, 0, 2'b00, 32'h0, 0, 32'h0, 0};
        run_txn(v, '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
        v = '{0, 32'h7000_0048, 4'hF, 32'h0, 0, 0, 0, 2, 1, 2'b00, 32'h1357_9BDF, 0, 32'h1357_9BDF, 0};
        run_txn(v, '{1'b0, 1'b0, 32'h0, 4'h0, 32'h0});
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
